// File: rtl/matrix_calc_pkg.sv
// Shared definitions for the matrix calculation sequencer: op codes, FSM states,
// default matrix dimension and the row-major address helper.
package matrix_calc_pkg;

  localparam int MAX_DIM_DEFAULT = 5;

  typedef enum logic [2:0] {
    OP_ADD       = 3'b000,
    OP_SUB       = 3'b001,
    OP_SCALAR    = 3'b010,
    OP_TRANSPOSE = 3'b011,
    OP_MULTIPLY  = 3'b100
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Row-major word address of element (row, col) in a dim x dim matrix slot.
  function automatic int lin_addr(input logic [2:0] row, input logic [2:0] col, input int dim);
    return int'(row) * dim + int'(col);
  endfunction

endpackage

// File: rtl/seq_index_counter.sv
// Nested i/j/k operand index counter with wrap and last-element flags.
// The k level exists only when CALC_SEQ_MATMUL_EN is defined; otherwise k is fixed at 0.
module seq_index_counter
  import matrix_calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_step,
  input  logic [2:0] i_i_cnt,
  input  logic [2:0] i_j_cnt,
`ifdef CALC_SEQ_MATMUL_EN
  input  logic [2:0] i_k_cnt,
`endif
  output logic [2:0] o_i,
  output logic [2:0] o_j,
  output logic [2:0] o_k,
  output logic       o_k_last,
  output logic       o_last
);

  logic [2:0] r_i;
  logic [2:0] r_j;
  logic       w_i_last;
  logic       w_j_last;
  logic       w_k_last;

  assign w_i_last = (r_i == i_i_cnt - 3'd1);
  assign w_j_last = (r_j == i_j_cnt - 3'd1);

`ifdef CALC_SEQ_MATMUL_EN
  logic [2:0] r_k;

  assign w_k_last = (r_k == i_k_cnt - 3'd1);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_k <= '0;
    end else if (i_step) begin
      r_k <= w_k_last ? 3'd0 : r_k + 3'd1;
    end
  end

  assign o_k = r_k;
`else
  assign w_k_last = 1'b1;
  assign o_k      = 3'd0;
`endif

  // j only moves when the inner level wraps; i only when j wraps.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_step && w_k_last) begin
      if (w_j_last) begin
        r_j <= '0;
        r_i <= w_i_last ? 3'd0 : r_i + 3'd1;
      end else begin
        r_j <= r_j + 3'd1;
      end
    end
  end

  assign o_i      = r_i;
  assign o_j      = r_j;
  assign o_k_last = w_k_last;
  assign o_last   = w_i_last && w_j_last && w_k_last;

endmodule

// File: rtl/calc_sequencer.sv
// Matrix operation sequencer: checks operand shapes, issues one operand read per
// unstalled cycle and drives the ALU accumulate / result-write pipeline.
// MULTIPLY is available only when CALC_SEQ_MATMUL_EN is defined.
// Handshake: calc_en is a start pulse accepted only in IDLE; stall freezes ISSUE/DRAIN.
module calc_sequencer
  import matrix_calc_pkg::*;
#(
  parameter int MAX_DIM = MAX_DIM_DEFAULT,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              calc_en,
  input  logic [2:0]        op_type,
  input  logic [2:0]        a_rows,
  input  logic [2:0]        a_cols,
  input  logic [2:0]        b_rows,
  input  logic [2:0]        b_cols,
  input  logic              stall,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [2:0]        alu_op,
  output logic              acc_load,
  output logic              acc_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              op_done,
  output logic              op_err
);

  state_e            r_state;
  logic [2:0]        r_op;
  logic [2:0]        r_ar;
  logic [2:0]        r_ac;
  logic [2:0]        r_br;
  logic [2:0]        r_bc;
  logic              r_err;
  logic              r_drain;
  logic              r_s1_vld;
  logic              r_s1_first;
  logic              r_s1_klast;
  logic [ADDR_W-1:0] r_s1_waddr;
  logic              r_s2_vld;
  logic [ADDR_W-1:0] r_wr_addr;

  logic              w_legal;
  logic              w_a_ok;
  logic              w_b_ok;
  logic              w_is_mul;
  logic              w_is_tr;
  logic              w_issue;
  logic              w_clear;
  logic [2:0]        w_i;
  logic [2:0]        w_j;
  logic [2:0]        w_k;
  logic [2:0]        w_j_cnt;
  logic              w_k_last;
  logic              w_last;
  logic [ADDR_W-1:0] w_waddr;

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (int'(d) <= MAX_DIM);
  endfunction

  assign w_a_ok = dim_ok(r_ar) && dim_ok(r_ac);
  assign w_b_ok = dim_ok(r_br) && dim_ok(r_bc);
  assign w_is_tr = (r_op == OP_TRANSPOSE);

`ifdef CALC_SEQ_MATMUL_EN
  logic [2:0] w_k_cnt;
  assign w_is_mul = (r_op == OP_MULTIPLY);
  assign w_k_cnt  = w_is_mul ? r_ac : 3'd1;
`else
  assign w_is_mul = 1'b0;
`endif

  always_comb begin
    w_legal = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB:          w_legal = w_a_ok && w_b_ok && (r_ar == r_br) && (r_ac == r_bc);
      OP_SCALAR, OP_TRANSPOSE: w_legal = w_a_ok;
`ifdef CALC_SEQ_MATMUL_EN
      OP_MULTIPLY:             w_legal = w_a_ok && w_b_ok && (r_ac == r_br);
`endif
      default:                 w_legal = 1'b0;
    endcase
  end

  assign w_j_cnt = w_is_mul ? r_bc : r_ac;
  assign w_issue = (r_state == S_ISSUE) && !stall;
  assign w_clear = (r_state == S_CHECK);

  seq_index_counter u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_step   (w_issue),
    .i_i_cnt  (r_ar),
    .i_j_cnt  (w_j_cnt),
`ifdef CALC_SEQ_MATMUL_EN
    .i_k_cnt  (w_k_cnt),
`endif
    .o_i      (w_i),
    .o_j      (w_j),
    .o_k      (w_k),
    .o_k_last (w_k_last),
    .o_last   (w_last)
  );

  // Counters hold under stall, so the addresses hold with them.
  assign rd_addr_a = ADDR_W'(lin_addr(w_i, w_is_mul ? w_k : w_j, MAX_DIM));
  assign rd_addr_b = ADDR_W'(lin_addr(w_is_mul ? w_k : w_i, w_j, MAX_DIM));
  assign w_waddr   = w_is_tr ? ADDR_W'(lin_addr(w_j, w_i, MAX_DIM))
                             : ADDR_W'(lin_addr(w_i, w_j, MAX_DIM));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_ar    <= '0;
      r_ac    <= '0;
      r_br    <= '0;
      r_bc    <= '0;
      r_err   <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (calc_en) begin
            r_op    <= op_type;
            r_ar    <= a_rows;
            r_ac    <= a_cols;
            r_br    <= b_rows;
            r_bc    <= b_cols;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_err   <= !w_legal;
          r_drain <= 1'b0;
          r_state <= w_legal ? S_ISSUE : S_DONE;
        end
        S_ISSUE: begin
          if (!stall && w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!stall) begin
            if (r_drain) begin
              r_drain <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_drain <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage 1 = accumulate, stage 2 = write; both advance only on unstalled cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_klast <= 1'b0;
      r_s1_waddr <= '0;
      r_s2_vld   <= 1'b0;
      r_wr_addr  <= '0;
    end else if (!stall) begin
      r_s1_vld   <= w_issue;
      r_s1_first <= (w_k == 3'd0);
      r_s1_klast <= w_k_last;
      r_s1_waddr <= w_waddr;
      r_s2_vld   <= r_s1_vld && r_s1_klast;
      if (r_s1_vld && r_s1_klast) r_wr_addr <= r_s1_waddr;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign rd_en    = w_issue;
  assign acc_load = r_s1_vld && r_s1_first && !stall;
  assign acc_en   = r_s1_vld && !r_s1_first && !stall;
  assign wr_en    = r_s2_vld && !stall;
  assign wr_addr  = r_wr_addr;
  assign alu_op   = r_op;
  assign op_done  = (r_state == S_DONE);
  assign op_err   = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed vector table, hand-written reset
// sequence and randomized operations checked against a cycle-level reference model.
module tb_calc_sequencer;

  localparam int MAX_DIM = 5;
  localparam int ADDR_W  = 5;
  localparam int MAXC    = 512;
  localparam int LIMIT   = 400;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              calc_en;
  logic [2:0]        op_type;
  logic [2:0]        a_rows, a_cols, b_rows, b_cols;
  logic              stall;
  logic              busy, rd_en, acc_load, acc_en, wr_en, op_done, op_err;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [2:0]        alu_op;

  always #5 clk = ~clk;

  calc_sequencer #(.MAX_DIM(MAX_DIM), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .calc_en(calc_en), .op_type(op_type),
    .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
    .stall(stall), .busy(busy), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .alu_op(alu_op), .acc_load(acc_load), .acc_en(acc_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .op_done(op_done), .op_err(op_err)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          stall_map [MAXC];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_acc_q[$];
  logic [31:0] exp_wr_q[$];
  int          got_wr[$];
  int          exp_done;
  bit          exp_err;

  typedef struct {
    int op, ar, ac, br, bc;
    int stall_at, stall_len;
    bit busy_pulse;
    int done_cyc;
    bit err;
    int n_wr;
    int wr[6];
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit dim_ok(input int d);
    return (d >= 1) && (d <= MAX_DIM);
  endfunction

  function automatic bit model_legal(input int op, input int ar, input int ac, input int br, input int bc);
    bit a_ok;
    bit b_ok;
    a_ok = dim_ok(ar) && dim_ok(ac);
    b_ok = dim_ok(br) && dim_ok(bc);
    case (op)
      0, 1:    return a_ok && b_ok && (ar == br) && (ac == bc);
      2, 3:    return a_ok;
`ifdef CALC_SEQ_MATMUL_EN
      4:       return a_ok && b_ok && (ac == br);
`endif
      default: return 1'b0;
    endcase
  endfunction

  // First cycle after 'after' in which stall is low.
  function automatic int next_free(input int after);
    int c;
    c = after + 1;
    while (c < MAXC - 1 && stall_map[c]) c++;
    return c;
  endfunction

  // Expected events, each stamped with its cycle (cycle 0 = calc_en cycle).
  task automatic build_model(input int op, input int ar, input int ac, input int br, input int bc);
    int rc, acc_c, wc, ni, nj, nk, a, b, w;
    exp_rd_q.delete();
    exp_acc_q.delete();
    exp_wr_q.delete();
    if (!model_legal(op, ar, ac, br, bc)) begin
      exp_done = 2;
      exp_err  = 1'b1;
      return;
    end
    exp_err = 1'b0;
    ni = ar;
    nj = (op == 4) ? bc : ac;
    nk = (op == 4) ? ac : 1;
    rc = 1;
    for (int i = 0; i < ni; i++) begin
      for (int j = 0; j < nj; j++) begin
        for (int k = 0; k < nk; k++) begin
          rc = next_free(rc);
          a  = (op == 4) ? i * MAX_DIM + k : i * MAX_DIM + j;
          b  = (op == 4) ? k * MAX_DIM + j : i * MAX_DIM + j;
          exp_rd_q.push_back({16'(rc), 8'(a), 8'(b)});
          acc_c = next_free(rc);
          exp_acc_q.push_back({16'(acc_c), 8'(k == 0), 8'(k != 0)});
          if (k == nk - 1) begin
            wc = next_free(acc_c);
            w  = (op == 3) ? j * MAX_DIM + i : i * MAX_DIM + j;
            exp_wr_q.push_back({16'(wc), 16'(w)});
          end
        end
      end
    end
    exp_done = next_free(next_free(rc)) + 1;
  endtask

  // ---------------- driver + monitor ----------------
  task automatic run_op(input int op, input int ar, input int ac, input int br, input int bc,
                        input bit busy_pulse, input bit scramble,
                        output int got_done, output bit got_err);
    int cyc;
    bit seen;
    build_model(op, ar, ac, br, bc);
    got_wr.delete();
    got_done = -1;
    got_err  = 1'b0;
    seen     = 1'b0;
    @(posedge clk); #1;
    op_type = 3'(op); a_rows = 3'(ar); a_cols = 3'(ac); b_rows = 3'(br); b_cols = 3'(bc);
    calc_en = 1'b1;
    stall   = stall_map[0];
    cyc     = 0;
    while (cyc < LIMIT) begin
      @(negedge clk);
      check("busy", busy, (cyc >= 1 && cyc <= exp_done));
      if (rd_en) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected_qlen", exp_rd_q.size(), 1);
        else check("rd_cyc_addr", {16'(cyc), 8'(rd_addr_a), 8'(rd_addr_b)}, exp_rd_q.pop_front());
      end
      if (acc_load || acc_en) begin
        if (exp_acc_q.size() == 0) check("acc_unexpected_qlen", exp_acc_q.size(), 1);
        else check("acc_cyc_kind", {16'(cyc), 8'(acc_load), 8'(acc_en)}, exp_acc_q.pop_front());
      end
      if (wr_en) begin
        got_wr.push_back(int'(wr_addr));
        if (exp_wr_q.size() == 0) check("wr_unexpected_qlen", exp_wr_q.size(), 1);
        else check("wr_cyc_addr", {16'(cyc), 16'(wr_addr)}, exp_wr_q.pop_front());
      end
      if (op_done) begin
        check("done_cycle", cyc, exp_done);
        check("done_err", op_err, exp_err);
        check("alu_op", alu_op, op);
        got_done = cyc;
        got_err  = op_err;
        seen     = 1'b1;
        break;
      end else if (op_err) begin
        check("err_without_done", op_err, 0);
      end
      @(posedge clk); #1;
      cyc++;
      calc_en = busy_pulse && ((cyc == 3 && exp_done > 3) || cyc == exp_done);
      stall   = stall_map[cyc];
      if (scramble && cyc >= 2) begin
        op_type = 3'($urandom_range(0, 7));
        a_rows  = 3'($urandom_range(0, 7));
        a_cols  = 3'($urandom_range(0, 7));
        b_rows  = 3'($urandom_range(0, 7));
        b_cols  = 3'($urandom_range(0, 7));
      end
    end
    if (!seen) check("done_timeout_cycle", cyc, exp_done);
    @(posedge clk); #1;
    calc_en = 1'b0;
    stall   = 1'b0;
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("rd_left", exp_rd_q.size(), 0);
    check("acc_left", exp_acc_q.size(), 0);
    check("wr_left", exp_wr_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr_a"}, rd_addr_a, 0);
    check({tag, "_rd_addr_b"}, rd_addr_b, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_acc_load"}, acc_load, 0);
    check({tag, "_acc_en"}, acc_en, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_op_done"}, op_done, 0);
    check({tag, "_op_err"}, op_err, 0);
  endtask

  function automatic vec_t mk(input int op, input int ar, input int ac, input int br, input int bc,
                              input int sa, input int sl, input bit bp, input int dc, input bit er,
                              input int nw, input int w0, input int w1, input int w2,
                              input int w3, input int w4, input int w5);
    vec_t v;
    v.op = op; v.ar = ar; v.ac = ac; v.br = br; v.bc = bc;
    v.stall_at = sa; v.stall_len = sl; v.busy_pulse = bp;
    v.done_cyc = dc; v.err = er; v.n_wr = nw;
    v.wr[0] = w0; v.wr[1] = w1; v.wr[2] = w2; v.wr[3] = w3; v.wr[4] = w4; v.wr[5] = w5;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int gd;
    bit ge;
    int activity;
    int op, ar, ac, br, bc;

    vecs.push_back(mk(0, 2, 3, 2, 3, 0, 0, 0, 10, 0, 6, 0, 1, 2, 5, 6, 7));
`ifdef CALC_SEQ_MATMUL_EN
    vecs.push_back(mk(4, 2, 3, 3, 2, 0, 0, 0, 16, 0, 4, 0, 1, 5, 6, 0, 0));
`else
    vecs.push_back(mk(4, 2, 3, 3, 2, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
`endif
    vecs.push_back(mk(3, 2, 3, 0, 0, 0, 0, 0, 10, 0, 6, 0, 5, 10, 1, 6, 11));
    vecs.push_back(mk(0, 2, 3, 3, 2, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4, 2, 3, 2, 3, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2, 3, 2, 3, 4, 3, 1, 13, 0, 6, 0, 1, 2, 5, 6, 7));
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(5, 2, 2, 2, 2, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, 5, 5, 0, 0, 0, 0, 0, 29, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 2, 0, 2, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 6, 1, 6, 1, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));

    rst_n = 1'b0; calc_en = 1'b0; stall = 1'b0;
    op_type = '0; a_rows = '0; a_cols = '0; b_rows = '0; b_cols = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      for (int c = 0; c < MAXC; c++) stall_map[c] = 1'b0;
      for (int c = vecs[v].stall_at; c < vecs[v].stall_at + vecs[v].stall_len; c++) stall_map[c] = 1'b1;
      run_op(vecs[v].op, vecs[v].ar, vecs[v].ac, vecs[v].br, vecs[v].bc,
             vecs[v].busy_pulse, 1'b1, gd, ge);
      check($sformatf("vec%0d_done_cycle", v), gd, vecs[v].done_cyc);
      check($sformatf("vec%0d_err", v), ge, vecs[v].err);
      if (vecs[v].n_wr > 0) begin
        check($sformatf("vec%0d_wr_count", v), got_wr.size(), vecs[v].n_wr);
        for (int i = 0; i < vecs[v].n_wr && i < got_wr.size(); i++)
          check($sformatf("vec%0d_wr_addr%0d", v, i), got_wr[i], vecs[v].wr[i]);
      end
    end

    // Reset asserted for one cycle in the middle of ISSUE of a SUB 3x3.
    for (int c = 0; c < MAXC; c++) stall_map[c] = 1'b0;
    @(posedge clk); #1;
    op_type = 3'd1; a_rows = 3'd3; a_cols = 3'd3; b_rows = 3'd3; b_cols = 3'd3;
    calc_en = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      calc_en = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    activity = 0;
    repeat (20) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (wr_en || op_done || busy || rd_en) activity++;
    end
    check("post_reset_quiet", activity, 0);
    run_op(0, 1, 1, 1, 1, 1'b0, 1'b0, gd, ge);
    check("post_reset_add1x1_done", gd, 5);
    check("post_reset_add1x1_err", ge, 0);

    // Randomized operations with random stall patterns.
    for (int t = 0; t < 40; t++) begin
      if (t % 8 == 7) op = $urandom_range(5, 7);
      else op = $urandom_range(0, 4);
      ar = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, MAX_DIM);
      ac = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, MAX_DIM);
      br = $urandom_range(1, MAX_DIM);
      bc = $urandom_range(1, MAX_DIM);
      if ($urandom_range(0, 9) < 7) begin
        br = (op == 4) ? ac : ar;
        bc = (op == 4) ? bc : ac;
      end
      for (int c = 0; c < MAXC; c++) stall_map[c] = ($urandom_range(0, 3) == 0);
      run_op(op, ar, ac, br, bc, 1'($urandom_range(0, 1)), 1'b1, gd, ge);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter MAX_DIM, default 5, maximum rows/cols per matrix; the allowed range is 2..7.
REQ-002 Parameter ADDR_W, default 5, matrix-memory word address width; it SHALL satisfy 2^ADDR_W >= MAX_DIM*MAX_DIM.
REQ-003 Ports SHALL be as follows (clock and reset first):
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- calc_en  in  1  start pulse from the main controller.
- op_type  in  3  operation: 000 ADD, 001 SUB, 010 SCALAR, 011 TRANSPOSE, 100 MULTIPLY; others reserved.
- a_rows, a_cols, b_rows, b_cols  in  3 each  operand dimensions, legal range 1..MAX_DIM.
- stall  in  1  freezes the whole pipeline while high.
- busy  out  1  operation in progress.
- rd_en  out  1  memory read strobe; read data returns 1 cycle later.
- rd_addr_a, rd_addr_b  out  ADDR_W each  operand addresses (row*MAX_DIM+col).
- alu_op  out  3  registered copy of op_type.
- acc_load  out  1  ALU loads the new product or result (first term).
- acc_en  out  1  ALU accumulates the new term.
- wr_en  out  1  result write strobe.
- wr_addr  out  ADDR_W  result address.
- op_done  out  1  one-cycle completion pulse.
- op_err  out  1  one-cycle error pulse, coincident with op_done.

Function
REQ-004 The FSM states SHALL be IDLE, CHECK, ISSUE, DRAIN, DONE; transitions:
- IDLE->CHECK on calc_en.
- CHECK->ISSUE when dimensions are legal, else CHECK->DONE with op_err.
- ISSUE->DRAIN after the last read.
- DRAIN->DONE after 2 unstalled cycles.
- DONE->IDLE unconditionally.
REQ-005 In CHECK, op_type, a_*, and b_* SHALL be latched; later input changes SHALL be ignored until IDLE.
REQ-006 Legality rules:
- All dimensions SHALL be in 1..MAX_DIM.
- ADD/SUB SHALL require a_rows==b_rows and a_cols==b_cols.
- MULTIPLY SHALL require a_cols==b_rows.
- SCALAR/TRANSPOSE SHALL check only A.
- A reserved op_type SHALL be an error.
REQ-007 In ISSUE, exactly one read SHALL be issued per unstalled cycle, using counters i (row), j (col), k (inner):
- MULTIPLY: nested i<a_rows, j<b_cols, k<a_cols; rd_addr_a=i*MAX_DIM+k, rd_addr_b=k*MAX_DIM+j.
- All other ops: k fixed at 0; i<a_rows, j<a_cols; rd_addr_a=rd_addr_b=i*MAX_DIM+j.
REQ-008 Pipeline: acc_load (k==0) or acc_en (k>0) SHALL assert 1 cycle after the matching rd_en.
REQ-009 wr_en SHALL assert 1 cycle after the acc stage of the last k of each element.
- wr_addr = i*MAX_DIM+j, except TRANSPOSE, where wr_addr = j*MAX_DIM+i.
REQ-010 Latency: with no stall, op_done SHALL pulse N+4 cycles after calc_en.
- N = a_rows*b_cols*a_cols for MULTIPLY; N = a_rows*a_cols otherwise.
REQ-011 When stall is high, the sequencer SHALL freeze as follows:
- Counters, the FSM, and the pipeline stage registers hold.
- rd_en, acc_load, acc_en, and wr_en are 0.
- Addresses hold.
- Stall in IDLE or CHECK SHALL have no effect.
REQ-012 calc_en while busy SHALL be ignored, with no restart and no error.
REQ-013 A calc_en in the same cycle as DONE SHALL be ignored; the next start is accepted from IDLE.
REQ-014 Counter wrap:
- k wraps to 0 and j increments; j wraps to 0 and i increments.
- The final wrap ends ISSUE with no extra read.
REQ-015 busy SHALL be 1 in CHECK, ISSUE, DRAIN, and DONE, and 0 in IDLE.

Reset
REQ-016 When rst_n is low at a clk edge:
- The FSM SHALL go to IDLE and all counters to 0.
- busy, rd_en, rd_addr_a, rd_addr_b, alu_op, acc_load, acc_en, wr_en, wr_addr, op_done, and op_err SHALL be 0.
REQ-017 Reset mid-operation SHALL abort immediately, with no further wr_en and no op_done.

Configuration
REQ-018 Macro CALC_SEQ_MATMUL_EN:
- Defined: MULTIPLY SHALL be supported as specified.
- Undefined: the k counter logic SHALL be omitted and op_type 100 SHALL be treated as reserved (op_err).

Structure
REQ-019 Package matrix_calc_pkg SHALL hold the op_type codes, the FSM state encoding, and the MAX_DIM default.
REQ-020 The nested i/j/k counter with wrap and last-flag SHALL be a sub-module named seq_index_counter.

Verification
REQ-021 The bench SHALL cover at least the following scenarios:
- ADD, A=B=2x3, no stall -> 6 reads at addresses 0,1,2,5,6,7; 6 wr_en at the same addresses; op_done at cycle 10; op_err=0.
- MULTIPLY, 2x3 * 3x2 -> 12 reads; acc_load on each k=0; 4 wr_en at addresses 0,1,5,6; op_done at cycle 16.
- TRANSPOSE 2x3 -> wr_addr sequence 0,5,10,1,6,11.
- ADD with A=2x3, B=3x2, and MULTIPLY 2x3 * 2x3 -> op_done and op_err in the same cycle at cycle 2; no rd_en.
- 3-cycle stall in the middle of ISSUE, plus calc_en pulsed while busy -> sequence unchanged, op_done delayed by exactly 3 cycles, no restart.
- rst_n low for 1 cycle during ISSUE -> all outputs 0 the next cycle; no op_done; a new ADD 1x1 then completes at cycle 5.
